// File: rtl/dense_pkg.sv
// Shared types and default sizing for the dense vector loader.
// Holds the loader state enum and the default WIDTH/INPUT_SIZE/HOLD_CYCLES.
package dense_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int WIDTH_DEF       = 16;
  localparam int INPUT_SIZE_DEF  = 128;
  localparam int HOLD_CYCLES_DEF = 8;

endpackage

// File: rtl/dense_hold_timer.sv
// Hold counter for the dense loader; busy spans the hold window.
// done pulses on its last cycle; start restarts the window at count 0.
module dense_hold_timer
  import dense_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt;

  assign done = busy && (cnt == LAST);

  // Count through the window; a start wins over the window ending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == LAST) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/dense_vector_loader.sv
// Serial-to-parallel loader feeding the dense-column pipeline.
// Define DENSE_LOADER_DOUBLE_BUF_EN for a live/shadow bank pair.
module dense_vector_loader
  import dense_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int INPUT_SIZE  = INPUT_SIZE_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] vec_data [0:INPUT_SIZE-1],
  output logic                    vec_valid,
  output logic                    tree_reset,
  output logic                    result_strobe,
  output logic                    short_frame
);

  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(INPUT_SIZE - 1);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] idx;
  logic          run;
  logic          acc;
  logic          close;
  logic          early;
  logic          launch;
  logic          busy;
  logic          done;

  assign acc   = in_valid && in_ready;
  assign close = acc && ((idx == LAST_IDX) || in_last);
  assign early = close && (idx != LAST_IDX);

  assign vec_valid     = (state == HOLD);
  assign result_strobe = done;

`ifdef DENSE_LOADER_DOUBLE_BUF_EN
  logic signed [WIDTH-1:0] bank [2][INPUT_SIZE];
  logic                    live;
  logic                    full;

  assign in_ready = run && !full;
  assign launch   = (!busy && close) || (done && (full || close));

  // Fill the shadow bank; swap banks whenever a vector launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < INPUT_SIZE; i++) begin
          bank[b][i] <= '0;
        end
      end
      live <= 1'b0;
      full <= 1'b0;
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (acc && (IW'(i) == idx)) begin
          bank[!live][i] <= in_data;
        end else if (close && (IW'(i) > idx)) begin
          bank[!live][i] <= '0;
        end
      end
      if (launch) begin
        live <= !live;
        full <= 1'b0;
      end else if (close) begin
        full <= 1'b1;
      end
    end
  end

  // Present the live bank.
  always_comb begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      vec_data[i] = bank[live][i];
    end
  end
`else
  logic signed [WIDTH-1:0] bank [INPUT_SIZE];

  assign in_ready = run && !busy;
  assign launch   = close;

  // Single bank: written in FILL, tail zeroed on an early close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        bank[i] <= '0;
      end
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (acc && (IW'(i) == idx)) begin
          bank[i] <= in_data;
        end else if (close && (IW'(i) > idx)) begin
          bank[i] <= '0;
        end
      end
    end
  end

  // Present the single bank.
  always_comb begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      vec_data[i] = bank[i];
    end
  end
`endif

  // State, write index, ready enable and launch pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      idx         <= '0;
      run         <= 1'b0;
      tree_reset  <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      state       <= state_nx;
      run         <= 1'b1;
      tree_reset  <= launch;
      short_frame <= early;
      if (close) begin
        idx <= '0;
      end else if (acc) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Next state: launch enters HOLD; hold end falls back unless relaunched.
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == FILL): begin
        if (launch) state_nx = HOLD;
      end
      (state == HOLD): begin
        if (done) state_nx = launch ? HOLD : FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  dense_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(launch),
    .busy (busy),
    .done (done)
  );

endmodule

// File: tb/tb_dense_vector_loader.sv
// Directed plus randomized bench for dense_vector_loader.
// Expected vectors and pulse timing come from a frame-level model.
module tb_dense_vector_loader;

  localparam int W  = 16;
  localparam int N  = 4;
`ifdef DENSE_LOADER_DOUBLE_BUF_EN
  localparam int HC = 6;
  localparam bit DB = 1'b1;
`else
  localparam int HC = 3;
  localparam bit DB = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic signed [W-1:0] vec_data [0:N-1];
  logic                vec_valid;
  logic                tree_reset;
  logic                result_strobe;
  logic                short_frame;

  int vectors = 0;
  int miscompares = 0;

  dense_vector_loader #(
    .WIDTH(W),
    .INPUT_SIZE(N),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .vec_data     (vec_data),
    .vec_valid    (vec_valid),
    .tree_reset   (tree_reset),
    .result_strobe(result_strobe),
    .short_frame  (short_frame)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] packv();
    return {vec_data[0], vec_data[1], vec_data[2], vec_data[3]};
  endfunction

  // Zero-padded expected vector from the accepted samples of a frame.
  function automatic logic [63:0] model_vec(input logic [W-1:0] s[$]);
    logic [W-1:0] v [N];
    for (int i = 0; i < N; i++) v[i] = (i < s.size()) ? s[i] : '0;
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk one hold window starting the cycle after the closing transfer.
  task automatic hold_check(input logic [63:0] expv, input bit early);
    for (int k = 1; k <= HC; k++) begin
      chk("hold_vec_valid", vec_valid, 1);
      chk("hold_tree_reset", tree_reset, (k == 1));
      chk("hold_strobe", result_strobe, (k == HC));
      chk("hold_short", short_frame, (k == 1) && early);
      chk("hold_in_ready", in_ready, DB);
      chk("hold_vec_data", packv(), expv);
      if (!DB) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("post_vec_valid", vec_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_strobe", result_strobe, 0);
  endtask

  // Stream one frame with optional idle gaps before each sample.
  task automatic send_frame(input logic [W-1:0] s[$], input int maxgap);
    int gap;
    for (int j = 0; j < s.size(); j++) begin
      gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
        tick();
        chk("gap_in_ready", in_ready, 1);
        chk("gap_vec_valid", vec_valid, 0);
      end
      chk("fill_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = s[j];
      if (j == s.size() - 1) begin
        in_last = (s.size() < N) ? 1'b1 : 1'($urandom);
      end else begin
        in_last = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] q[$];
    bit pat [7];
    int len;
    int si;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_tree_reset", tree_reset, 0);
    chk("rst_strobe", result_strobe, 0);
    chk("rst_short", short_frame, 0);
    chk("rst_vec_data", packv(), 0);
    tick();
    chk("rst_edge_in_ready", in_ready, 0);
    rst_n = 1'b1;
    chk("rel_in_ready", in_ready, 0);
    tick();
    chk("first_edge_in_ready", in_ready, 1);

    q = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_frame(q, 0);
    hold_check(model_vec(q), 1'b0);

    q = '{16'd7, -16'sd5};
    send_frame(q, 0);
    hold_check(model_vec(q), 1'b1);

    pat = '{1, 0, 0, 1, 1, 0, 1};
    si = 0;
    for (int c = 0; c < 7; c++) begin
      chk("pat_in_ready", in_ready, 1);
      chk("pat_vec_valid", vec_valid, 0);
      in_valid = pat[c];
      in_last  = 1'b0;
      in_data  = pat[c] ? W'(9 + si) : W'($urandom);
      if (pat[c]) si++;
      tick();
    end
    in_valid = 1'b0;
    q = '{16'd9, 16'd10, 16'd11, 16'd12};
    hold_check(model_vec(q), 1'b0);

    q = '{16'd21, 16'd22, 16'd23, 16'd24};
    send_frame(q, 0);
    chk("pre_rst_tree_reset", tree_reset, 1);
    tick();
    chk("pre_rst_vec_valid", vec_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vec_valid", vec_valid, 0);
    chk("mid_rst_vec_data", packv(), 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < HC + 2; k++) begin
      tick();
      chk("after_rst_strobe", result_strobe, 0);
      chk("after_rst_vec_valid", vec_valid, 0);
    end
    q = '{16'd31, 16'd32, 16'd33, 16'd34};
    send_frame(q, 0);
    hold_check(model_vec(q), 1'b0);

`ifdef DENSE_LOADER_DOUBLE_BUF_EN
    q = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_frame(q, 0);
    for (int k = 1; k <= HC; k++) begin
      chk("db_a_vec", packv(), model_vec(q));
      chk("db_a_tree_reset", tree_reset, (k == 1));
      chk("db_a_strobe", result_strobe, (k == HC));
      chk("db_a_in_ready", in_ready, (k <= N));
      in_valid = (k <= N);
      in_data  = W'(4 + k);
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    q = '{16'd5, 16'd6, 16'd7, 16'd8};
    for (int k = 1; k <= HC; k++) begin
      chk("db_b_vec_valid", vec_valid, 1);
      chk("db_b_vec", packv(), model_vec(q));
      chk("db_b_tree_reset", tree_reset, (k == 1));
      chk("db_b_strobe", result_strobe, (k == HC));
      tick();
    end
    chk("db_b_end_vec_valid", vec_valid, 0);
`endif

    for (int f = 0; f < 14; f++) begin
      q.delete();
      len = $urandom_range(1, N);
      for (int j = 0; j < len; j++) q.push_back(W'($urandom));
      send_frame(q, 2);
      hold_check(model_vec(q), (len < N));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
